uart_reg_writer: RTL and testbench

//  Serial front end for the signal generator register file. Receives 8N1 UART bytes on one pin.

---
 rtl/uart_reg_pkg.sv | 17 +
 rtl/uart_rx_core.sv | 109 ++++++++++
 rtl/uart_reg_writer.sv | 80 ++++++++
 tb/tb_uart_reg_writer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_reg_pkg.sv
// Shared types and helpers for the UART register-write front end.
package uart_reg_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 5;

  // Minimum bits to hold values 0..value-1 (never less than 1).
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width = width + 1;
    return width;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling FSM, registered byte/frame-error pulses.
module uart_rx_core
  import uart_reg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW = clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic            sync1_q, rx_s_q;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_in;
      rx_s_q  <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        // Half a bit in: a line that is high again was only a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        // A held-low line reports one frame error, then waits for idle.
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign rx_byte    = shift_q;
  assign frame_err  = ferr_q;
  assign rx_busy    = (state_q != IDLE);

endmodule

// File: rtl/uart_reg_writer.sv
// Turns each received UART byte into a held register-write strobe for the slow register domain.
module uart_reg_writer
  import uart_reg_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 87,
  parameter int STROBE_CYCLES = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              write_strobe,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int SW = clog2(STROBE_CYCLES + 1);
  localparam logic [SW-1:0] STROBE_LOAD = SW'(STROBE_CYCLES);

  logic              byte_valid;
  logic [7:0]        rx_byte;
  logic              rx_busy;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic              ovr_q, ovr_d;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
      scnt_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      scnt_q <= scnt_d;
      ovr_q  <= ovr_d;
    end
  end

  // Strobe is high exactly while the down-counter is non-zero.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    ovr_d  = 1'b0;
    scnt_d = (scnt_q != '0) ? scnt_q - 1'b1 : scnt_q;
    if (byte_valid) begin
      if (scnt_q == '0) begin
        addr_d = rx_byte[ADDR_W-1:0];
        data_d = rx_byte[7:ADDR_W];
        scnt_d = STROBE_LOAD;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign address      = addr_q;
  assign data         = data_q;
  assign write_strobe = (scnt_q != '0);
  assign busy         = rx_busy | write_strobe;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_uart_reg_writer.sv
// Directed + randomized bench for uart_reg_writer; a second instance covers the long-strobe overrun case.
module tb_uart_reg_writer;

  localparam int C       = 8;
  localparam int S       = 20;
  localparam int S2      = 200;
  localparam int LAT_NOM = 3 + C / 2 + 9 * C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic       rx2 = 1'b1;
  logic [2:0] address, address2;
  logic [4:0] data, data2;
  logic       write_strobe, ws2, busy, busy2, frame_err, fe2, overrun, ov2;

  int checks = 0;
  int errors = 0;
  int cyc = 0, fall_cyc = 0, rise_start = 0;
  int rise_cnt = 0, fe_cnt = 0, ov_cnt = 0, busy_bad = 0;
  int rise2_cnt = 0, fe2_cnt = 0, ov2_cnt = 0;
  logic ws_prev = 1'b0, ws2_prev = 1'b0;
  int mon_lat[$], mon_addr[$], mon_data[$], mon_len[$];

  always #5 clk = ~clk;

  uart_reg_writer #(.CLKS_PER_BIT(C), .STROBE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .address(address), .data(data),
    .write_strobe(write_strobe), .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  uart_reg_writer #(.CLKS_PER_BIT(C), .STROBE_CYCLES(S2)) dut2 (
    .clk(clk), .rst(rst), .rx_in(rx2), .address(address2), .data(data2),
    .write_strobe(ws2), .busy(busy2), .frame_err(fe2), .overrun(ov2)
  );

  // Observation of strobe edges and pulses, sampled mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (write_strobe && !ws_prev) begin
      rise_cnt = rise_cnt + 1;
      mon_lat.push_back(cyc - fall_cyc);
      mon_addr.push_back(int'(address));
      mon_data.push_back(int'(data));
      rise_start = cyc;
    end
    if (!write_strobe && ws_prev) mon_len.push_back(cyc - rise_start);
    ws_prev = write_strobe;
    if (write_strobe && !busy) busy_bad = busy_bad + 1;
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (overrun) ov_cnt = ov_cnt + 1;
    if (ws2 && !ws2_prev) rise2_cnt = rise2_cnt + 1;
    ws2_prev = ws2;
    if (fe2) fe2_cnt = fe2_cnt + 1;
    if (ov2) ov2_cnt = ov2_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 0) rx_in = v;
    else rx2 = v;
  endtask

  // A zero stop bit leaves the line low afterwards (break condition).
  task automatic send_byte(input int which, input logic [7:0] b, input logic stop_bit, input int gap);
    if (which == 0) fall_cyc = cyc + 1;
    drive(which, 1'b0);
    wait_cyc(C);
    for (int i = 0; i < 8; i++) begin
      drive(which, b[i]);
      wait_cyc(C);
    end
    drive(which, stop_bit);
    wait_cyc(C);
    if (stop_bit) begin
      drive(which, 1'b1);
      wait_cyc(gap);
    end
  endtask

  task automatic expect_write(input string tag, input int exp_addr, input int exp_data);
    int n;
    int lat;
    n = 0;
    while (mon_len.size() == 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({tag, " strobe_seen"}, 32'(mon_len.size() != 0 && mon_addr.size() != 0), 32'd1);
    if (mon_len.size() != 0 && mon_addr.size() != 0) begin
      check({tag, " addr"}, 32'(mon_addr.pop_front()), 32'(exp_addr));
      check({tag, " data"}, 32'(mon_data.pop_front()), 32'(exp_data));
      check({tag, " strobe_len"}, 32'(mon_len.pop_front()), 32'(S));
      lat = mon_lat.pop_front();
      checks++;
      assert (lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1) else begin
        errors++;
        $error("FAIL %s latency: observed %0d expected %0d+/-1", tag, lat, LAT_NOM);
      end
      $display("write %s: addr=%0d data=%0d latency=%0d", tag, exp_addr, exp_data, lat);
    end
  endtask

  initial begin
    int r, f, bi;

    // Reset state
    rst = 1'b1;
    wait_cyc(3);
    check("rst address", 32'(address), 0);
    check("rst data", 32'(data), 0);
    check("rst write_strobe", 32'(write_strobe), 0);
    check("rst busy", 32'(busy), 0);
    check("rst frame_err", 32'(frame_err), 0);
    check("rst overrun", 32'(overrun), 0);
    rst = 1'b0;
    wait_cyc(5);

    // 1: single byte
    send_byte(0, 8'h2B, 1'b1, 3);
    expect_write("t1_2B", 3, 5);
    check("t1 busy_during_strobe", 32'(busy_bad), 0);

    // 2: extremes
    send_byte(0, 8'h00, 1'b1, 30);
    expect_write("t2_00", 0, 0);
    send_byte(0, 8'hFF, 1'b1, 30);
    expect_write("t2_FF", 7, 31);

    // Randomized bytes against the field-split model
    for (int i = 0; i < 10; i++) begin
      bi = int'($urandom_range(0, 255));
      send_byte(0, 8'(bi), 1'b1, int'($urandom_range(2, 40)));
      expect_write("rand", bi % 8, bi / 8);
    end

    // 3: short glitch on the line
    r = rise_cnt;
    f = fe_cnt;
    drive(0, 1'b0);
    wait_cyc(3);
    drive(0, 1'b1);
    wait_cyc(150);
    check("t3 no_strobe", 32'(rise_cnt), 32'(r));
    check("t3 no_frame_err", 32'(fe_cnt), 32'(f));
    check("t3 idle", 32'(busy), 0);

    // 4: framing error followed by break, then recovery
    r = rise_cnt;
    f = fe_cnt;
    send_byte(0, 8'h55, 1'b0, 0);
    wait_cyc(50);
    drive(0, 1'b1);
    wait_cyc(20);
    check("t4 one_frame_err", 32'(fe_cnt), 32'(f + 1));
    check("t4 no_strobe", 32'(rise_cnt), 32'(r));
    send_byte(0, 8'h2B, 1'b1, 3);
    expect_write("t4_2B", 3, 5);
    check("t4 frame_err_total", 32'(fe_cnt), 32'(f + 1));

    // 5: long strobe, back-to-back bytes on the second instance
    send_byte(1, 8'h11, 1'b1, 0);
    send_byte(1, 8'h22, 1'b1, 20);
    check("t5 overrun_once", 32'(ov2_cnt), 1);
    check("t5 strobe_still_high", 32'(ws2), 1);
    check("t5 address", 32'(address2), 1);
    check("t5 data", 32'(data2), 2);
    wait_cyc(300);
    check("t5 strobe_done", 32'(ws2), 0);
    check("t5 address_held", 32'(address2), 1);
    check("t5 data_held", 32'(data2), 2);
    check("t5 single_strobe", 32'(rise2_cnt), 1);
    $display("t5: overrun pulses=%0d strobes=%0d", ov2_cnt, rise2_cnt);

    // 6a: reset during data bit 4
    r = rise_cnt;
    drive(0, 1'b0);
    wait_cyc(C);
    for (int i = 0; i < 4; i++) begin
      drive(0, bi[i] ^ 1'b1);
      wait_cyc(C);
    end
    drive(0, 1'b1);
    wait_cyc(C / 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6a address", 32'(address), 0);
    check("t6a data", 32'(data), 0);
    check("t6a write_strobe", 32'(write_strobe), 0);
    check("t6a busy", 32'(busy), 0);
    check("t6a frame_err", 32'(frame_err), 0);
    check("t6a overrun", 32'(overrun), 0);
    rst = 1'b0;
    wait_cyc(150);
    check("t6a partial_discarded", 32'(rise_cnt), 32'(r));
    send_byte(0, 8'h2B, 1'b1, 3);
    expect_write("t6a_2B", 3, 5);

    // 6b: reset during an active strobe
    send_byte(0, 8'h2B, 1'b1, 2);
    check("t6b strobe_active", 32'(write_strobe), 1);
    wait_cyc(5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6b address", 32'(address), 0);
    check("t6b data", 32'(data), 0);
    check("t6b write_strobe", 32'(write_strobe), 0);
    check("t6b busy", 32'(busy), 0);
    rst = 1'b0;
    wait_cyc(2);
    mon_lat.delete();
    mon_addr.delete();
    mon_data.delete();
    mon_len.delete();
    wait_cyc(20);
    send_byte(0, 8'h2B, 1'b1, 3);
    expect_write("t6b_2B", 3, 5);

    // Whole-run invariants
    check("main overrun_none", 32'(ov_cnt), 0);
    check("busy_covers_strobe", 32'(busy_bad), 0);
    check("dut2 frame_err_none", 32'(fe2_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
